// File: rtl/jpeg_stream_merge.sv
// Merges the Y, Cb and Cr JPEG word streams into one stream in MCU block order.
// Each channel has its own FIFO. A round-robin arbiter moves on only after a block_end word.
module jpeg_stream_merge #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             y_JPEG_bitstream,
  input  logic                    y_data_ready,
  input  logic                    y_block_end,
  input  logic [31:0]             cb_JPEG_bitstream,
  input  logic                    cb_data_ready,
  input  logic                    cb_block_end,
  input  logic [31:0]             cr_JPEG_bitstream,
  input  logic                    cr_data_ready,
  input  logic                    cr_block_end,
  output logic [31:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_chan,
  output logic                    out_mcu_end,
  output logic [2:0]              overflow,
  output logic [1:0]              dbg_state,
  output logic [$clog2(DEPTH):0]  dbg_y_count,
  output logic [$clog2(DEPTH):0]  dbg_cb_count,
  output logic [$clog2(DEPTH):0]  dbg_cr_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    SEL_Y  = 2'd0,
    SEL_CB = 2'd1,
    SEL_CR = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [32:0]   mem [3][DEPTH];
  logic [AW-1:0] wr_ptr [3];
  logic [AW-1:0] rd_ptr [3];
  logic [CW-1:0] cnt [3];
  logic [31:0]   in_word [3];
  logic [2:0]    in_req, in_tag, push_ok, pop, sel_mask;
  logic [32:0]   sel_head;
  logic          sel_nonempty, out_free, pop_any;

  assign in_word[0] = y_JPEG_bitstream;
  assign in_word[1] = cb_JPEG_bitstream;
  assign in_word[2] = cr_JPEG_bitstream;
  assign in_req     = {cr_data_ready, cb_data_ready, y_data_ready};
  assign in_tag     = {cr_block_end, cb_block_end, y_block_end};

  // Output handshake: a word transfers on any edge where out_valid && out_ready;
  // while out_valid is high and out_ready is low the output register holds still.
  assign out_free = !out_valid || out_ready;

  always_comb begin
    sel_head     = '0;
    sel_nonempty = 1'b0;
    sel_mask     = 3'b000;
    state_next   = state;
    case (state)
      SEL_Y: begin
        sel_head     = mem[0][rd_ptr[0]];
        sel_nonempty = (cnt[0] != '0);
        sel_mask     = 3'b001;
      end
      SEL_CB: begin
        sel_head     = mem[1][rd_ptr[1]];
        sel_nonempty = (cnt[1] != '0);
        sel_mask     = 3'b010;
      end
      SEL_CR: begin
        sel_head     = mem[2][rd_ptr[2]];
        sel_nonempty = (cnt[2] != '0);
        sel_mask     = 3'b100;
      end
      default: ;
    endcase
    pop_any = sel_nonempty && out_free;
    pop     = pop_any ? sel_mask : 3'b000;
    // A full FIFO still accepts a word when it is popped on the same edge.
    for (int c = 0; c < 3; c++) begin
      push_ok[c] = in_req[c] && ((cnt[c] != CW'(DEPTH)) || pop[c]);
    end
    if (pop_any && sel_head[32]) begin
      case (state)
        SEL_Y:   state_next = SEL_CB;
        SEL_CB:  state_next = SEL_CR;
        default: state_next = SEL_Y;
      endcase
    end else if (state != SEL_Y && state != SEL_CB && state != SEL_CR) begin
      state_next = SEL_Y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SEL_Y;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_chan    <= 2'd0;
      out_mcu_end <= 1'b0;
      overflow    <= 3'b000;
      for (int c = 0; c < 3; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
    end else begin
      state <= state_next;
      for (int c = 0; c < 3; c++) begin
        if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + AW'(1);
        if (pop[c])     rd_ptr[c] <= rd_ptr[c] + AW'(1);
        cnt[c] <= cnt[c] + CW'(push_ok[c]) - CW'(pop[c]);
        if (in_req[c] && !push_ok[c]) overflow[c] <= 1'b1;
      end
      if (pop_any) begin
        out_data    <= sel_head[31:0];
        out_chan    <= state;
        out_mcu_end <= (state == SEL_CR) && sel_head[32];
        out_valid   <= 1'b1;
      end else if (out_ready) begin
        out_valid   <= 1'b0;
      end
    end
  end

  // Storage carries no reset; pointers and counts define what is live.
  always_ff @(posedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (push_ok[c]) mem[c][wr_ptr[c]] <= {in_tag[c], in_word[c]};
    end
  end

  assign dbg_state    = state;
  assign dbg_y_count  = cnt[0];
  assign dbg_cb_count = cnt[1];
  assign dbg_cr_count = cnt[2];

endmodule

// File: tb/tb_jpeg_stream_merge.sv
// Directed bench for jpeg_stream_merge: a vector table for block ordering plus
// hand-written sequences for blocking, backpressure, overflow and reset.
module tb_jpeg_stream_merge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] y_w, cb_w, cr_w;
  logic        y_v, y_t, cb_v, cb_t, cr_v, cr_t;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_mcu_end;
  logic [1:0]  out_chan, dbg_state;
  logic [2:0]  overflow;
  logic [4:0]  dbg_y_count, dbg_cb_count, dbg_cr_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];

  typedef struct packed {
    logic        y_v;  logic [31:0] y_w;  logic y_t;
    logic        cb_v; logic [31:0] cb_w; logic cb_t;
    logic        cr_v; logic [31:0] cr_w; logic cr_t;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_chan;
    logic        exp_mcu;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs [8];

  jpeg_stream_merge #(.DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .y_JPEG_bitstream(y_w), .y_data_ready(y_v), .y_block_end(y_t),
    .cb_JPEG_bitstream(cb_w), .cb_data_ready(cb_v), .cb_block_end(cb_t),
    .cr_JPEG_bitstream(cr_w), .cr_data_ready(cr_v), .cr_block_end(cr_t),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_chan(out_chan), .out_mcu_end(out_mcu_end), .overflow(overflow),
    .dbg_state(dbg_state), .dbg_y_count(dbg_y_count),
    .dbg_cb_count(dbg_cb_count), .dbg_cr_count(dbg_cr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    y_v = 0; y_t = 0; y_w = '0;
    cb_v = 0; cb_t = 0; cb_w = '0;
    cr_v = 0; cr_t = 0; cr_w = '0;
  endtask

  task automatic do_reset();
    clear_in();
    out_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] ew(input logic [1:0] chan, input logic mcu, input logic [31:0] data);
    return {chan, mcu, data};
  endfunction

  // One clock: an accepted word is scored against the head of exp_q.
  task automatic step();
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_word: got %h expected none", {out_chan, out_mcu_end, out_data});
      end else begin
        chk("stream_word", {out_chan, out_mcu_end, out_data}, exp_q.pop_front());
      end
    end
    tick();
  endtask

  task automatic drain(input int budget, output int cycles);
    out_ready = 1'b1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      step();
      cycles++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int cyc;
    vecs[0] = '{1'b1, 32'hA0000001, 1'b0, 1'b1, 32'hB0000001, 1'b1, 1'b1, 32'hC0000001, 1'b0,
                1'b0, 32'h0, 2'd0, 1'b0, 2'd0};
    vecs[1] = '{1'b1, 32'hA0000002, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0000002, 1'b1,
                1'b1, 32'hA0000001, 2'd0, 1'b0, 2'd0};
    vecs[2] = '{1'b1, 32'hA0000003, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'hA0000002, 2'd0, 1'b0, 2'd0};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'hA0000003, 2'd0, 1'b0, 2'd1};
    vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'hB0000001, 2'd1, 1'b0, 2'd2};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'hC0000001, 2'd2, 1'b0, 2'd2};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b1, 32'hC0000002, 2'd2, 1'b1, 2'd0};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                1'b0, 32'h0, 2'd0, 1'b0, 2'd0};

    // Reset values
    do_reset();
    chk("rst_out_data", 35'(out_data), 35'(32'h0));
    chk("rst_out_valid", 35'(out_valid), 35'(1'b0));
    chk("rst_out_chan", 35'(out_chan), 35'(2'd0));
    chk("rst_out_mcu_end", 35'(out_mcu_end), 35'(1'b0));
    chk("rst_overflow", 35'(overflow), 35'(3'b000));
    chk("rst_state", 35'(dbg_state), 35'(2'd0));

    // Basic MCU ordering from the vector table
    for (int i = 0; i < 8; i++) begin
      y_v = vecs[i].y_v;   y_w = vecs[i].y_w;   y_t = vecs[i].y_t;
      cb_v = vecs[i].cb_v; cb_w = vecs[i].cb_w; cb_t = vecs[i].cb_t;
      cr_v = vecs[i].cr_v; cr_w = vecs[i].cr_w; cr_t = vecs[i].cr_t;
      tick();
      chk("vec_valid", 35'(out_valid), 35'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk("vec_word", {out_chan, out_mcu_end, out_data},
            ew(vecs[i].exp_chan, vecs[i].exp_mcu, vecs[i].exp_data));
      end
      chk("vec_state", 35'(dbg_state), 35'(vecs[i].exp_state));
    end
    clear_in();

    // Cb/Cr words wait until a Y block has gone out
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cb_v = 1; cb_w = 32'hB1000000 + 32'(i); cb_t = (i == 4);
      cr_v = 1; cr_w = 32'hC1000000 + 32'(i); cr_t = 1'b0;
      tick();
      chk("block_no_valid", 35'(out_valid), 35'(1'b0));
    end
    clear_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("block_idle", 35'(out_valid), 35'(1'b0));
    end
    exp_q.push_back(ew(2'd0, 1'b0, 32'hA5A5A5A5));
    for (int i = 0; i < 5; i++) exp_q.push_back(ew(2'd1, 1'b0, 32'hB1000000 + 32'(i)));
    for (int i = 0; i < 5; i++) exp_q.push_back(ew(2'd2, 1'b0, 32'hC1000000 + 32'(i)));
    y_v = 1; y_w = 32'hA5A5A5A5; y_t = 1;
    tick();
    clear_in();
    drain(40, cyc);

    // Backpressure: output holds, FIFO count frozen, then 1 word per cycle
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      y_v = 1; y_w = 32'hD0000000 + 32'(i); y_t = (i == 4);
      tick();
    end
    clear_in();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_word", {out_valid, out_chan, out_mcu_end, out_data[30:0]},
          {1'b1, 2'd0, 1'b0, 31'h50000001});
      chk("bp_hold_count", 35'(dbg_y_count), 35'(5'd3));
    end
    for (int i = 1; i <= 4; i++) exp_q.push_back(ew(2'd0, 1'b0, 32'hD0000000 + 32'(i)));
    drain(20, cyc);
    chk("bp_throughput_cycles", 35'(cyc), 35'(4));

    // Overflow while Y is not selected
    do_reset();
    exp_q.push_back(ew(2'd0, 1'b0, 32'hE0000000));
    y_v = 1; y_w = 32'hE0000000; y_t = 1;
    tick();
    clear_in();
    drain(10, cyc);
    chk("ovf_state_cb", 35'(dbg_state), 35'(2'd1));
    for (int i = 1; i <= 17; i++) begin
      y_v = 1; y_w = 32'hE1000000 + 32'(i); y_t = (i >= 16);
      tick();
    end
    clear_in();
    chk("ovf_count", 35'(dbg_y_count), 35'(5'd16));
    chk("ovf_flag", 35'(overflow), 35'(3'b001));
    exp_q.push_back(ew(2'd1, 1'b0, 32'hB2000001));
    exp_q.push_back(ew(2'd2, 1'b1, 32'hC2000001));
    for (int i = 1; i <= 16; i++) exp_q.push_back(ew(2'd0, 1'b0, 32'hE1000000 + 32'(i)));
    cb_v = 1; cb_w = 32'hB2000001; cb_t = 1;
    cr_v = 1; cr_w = 32'hC2000001; cr_t = 1;
    step();
    clear_in();
    drain(40, cyc);
    chk("ovf_flag_sticky", 35'(overflow), 35'(3'b001));

    // Full FIFO accepts a push on a popping cycle
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      y_v = 1; y_w = 32'hF0000000 + 32'(i); y_t = 0;
      tick();
    end
    clear_in();
    chk("full_count", 35'(dbg_y_count), 35'(5'd16));
    chk("full_no_ovf", 35'(overflow), 35'(3'b000));
    for (int i = 1; i <= 18; i++) exp_q.push_back(ew(2'd0, 1'b0, 32'hF0000000 + 32'(i)));
    out_ready = 1'b1;
    y_v = 1; y_w = 32'hF0000012; y_t = 1;
    step();
    clear_in();
    chk("full_pop_count", 35'(dbg_y_count), 35'(5'd16));
    chk("full_pop_no_ovf", 35'(overflow), 35'(3'b000));
    drain(40, cyc);

    // Reset in the middle of buffered traffic
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cb_v = 1; cb_w = 32'hBB000000 + 32'(i); cb_t = 0;
      y_v = (i < 2); y_w = 32'hAA000000 + 32'(i); y_t = 0;
      cr_v = (i == 0); cr_w = 32'hCC000000; cr_t = 0;
      tick();
    end
    clear_in();
    chk("pre_rst_valid", 35'(out_valid), 35'(1'b1));
    chk("pre_rst_ovf", 35'(overflow), 35'(3'b010));
    rst = 1'b1;
    y_v = 1; y_w = 32'hDEADBEEF; y_t = 1;
    tick();
    rst = 1'b0;
    clear_in();
    chk("mid_rst_valid", 35'(out_valid), 35'(1'b0));
    chk("mid_rst_ovf", 35'(overflow), 35'(3'b000));
    chk("mid_rst_state", 35'(dbg_state), 35'(2'd0));
    chk("mid_rst_counts", {20'h0, dbg_y_count, dbg_cb_count, dbg_cr_count}, 35'h0);
    out_ready = 1'b1;
    y_v = 1; y_w = 32'h5A5A5A5A; y_t = 1;
    tick();
    clear_in();
    chk("post_rst_lat1", 35'(out_valid), 35'(1'b0));
    tick();
    chk("post_rst_valid", 35'(out_valid), 35'(1'b1));
    chk("post_rst_word", {out_chan, out_mcu_end, out_data}, ew(2'd0, 1'b0, 32'h5A5A5A5A));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
